// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier between N_REQ requesters.
// Latches the winner's operands, runs one start/busy handshake and acks the product, with a watchdog.
module mul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [N_REQ*W-1:0] a_bi,
  input  logic [N_REQ*W-1:0] b_bi,
  output logic [N_REQ-1:0]   ack_o,
  output logic [2*W-1:0]     y_bo,
  output logic               err_o,
  output logic               busy_o,
  output logic [W-1:0]       mul_a_bo,
  output logic [W-1:0]       mul_b_bo,
  output logic               mul_start_o,
  input  logic               mul_busy_i,
  input  logic [2*W-1:0]     mul_y_bi
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] LAST_IDX = GW'(N_REQ - 1);
  // The START cycle counts toward the window, so expiry at TIMEOUT-2 puts the ack TIMEOUT cycles after START.
  localparam logic [CW-1:0] EXPIRE = CW'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  state_t           r_state;
  logic [GW-1:0]    r_ptr;
  logic [GW-1:0]    r_grant;
  logic [CW-1:0]    r_cnt;
  logic [N_REQ-1:0] r_ack;
  logic [2*W-1:0]   r_y;
  logic             r_err;
  logic             r_busy;
  logic             r_start;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;

  logic             w_found;
  logic [GW-1:0]    w_grant;
  logic [GW-1:0]    w_cand;
  logic [GW-1:0]    w_ptr_next;
  logic [W-1:0]     w_a;
  logic [W-1:0]     w_b;
  logic [N_REQ-1:0] w_onehot;
  logic             w_expired;

  // Scan from the highest offset down so the request closest to r_ptr is the one left standing.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_cand  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_cand = GW'((int'(r_ptr) + i) % N_REQ);
      if (req_i[w_cand]) begin
        w_found = 1'b1;
        w_grant = w_cand;
      end
    end
  end

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_grant == GW'(k)) begin
        w_a = a_bi[k*W +: W];
        w_b = b_bi[k*W +: W];
      end
    end
  end

  assign w_ptr_next = (w_grant == LAST_IDX) ? '0 : w_grant + 1'b1;
  assign w_onehot   = {{(N_REQ-1){1'b0}}, 1'b1} << r_grant;
  assign w_expired  = (r_cnt == EXPIRE);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_cnt   <= '0;
      r_ack   <= '0;
      r_y     <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_start <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_ack   <= '0;
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_grant;
            r_ptr   <= w_ptr_next;
            r_a     <= w_a;
            r_b     <= w_b;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_expired) begin
            r_y     <= '0;
            r_err   <= 1'b1;
            r_ack   <= w_onehot;
            r_state <= S_RESP;
          end else if (mul_busy_i) begin
            r_state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          r_cnt <= r_cnt + 1'b1;
          // The watchdog wins even if busy drops in the same cycle.
          if (w_expired) begin
            r_y     <= '0;
            r_err   <= 1'b1;
            r_ack   <= w_onehot;
            r_state <= S_RESP;
          end else if (!mul_busy_i) begin
            r_y     <= mul_y_bi;
            r_err   <= 1'b0;
            r_ack   <= w_onehot;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ack_o       = r_ack;
  assign y_bo        = r_y;
  assign err_o       = r_err;
  assign busy_o      = r_busy;
  assign mul_start_o = r_start;
  assign mul_a_bo    = r_a;
  assign mul_b_bo    = r_b;

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter: round-robin reference model, behavioural multiplier with
// configurable busy length or stuck mode, and a monitor that checks every ack against the queue.
module tb_mul_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int T = 16;

  logic           clk = 1'b0;
  logic           rst_i = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] aBus = '0;
  logic [N*W-1:0] bBus = '0;
  logic [N-1:0]   ack_o;
  logic [2*W-1:0] y_bo;
  logic           err_o;
  logic           busy_o;
  logic [W-1:0]   mul_a_bo;
  logic [W-1:0]   mul_b_bo;
  logic           mul_start_o;
  logic           mulBusy = 1'b0;
  logic [2*W-1:0] mulY = '0;

  mul_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(T)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req), .a_bi(aBus), .b_bi(bBus),
    .ack_o(ack_o), .y_bo(y_bo), .err_o(err_o), .busy_o(busy_o),
    .mul_a_bo(mul_a_bo), .mul_b_bo(mul_b_bo), .mul_start_o(mul_start_o),
    .mul_busy_i(mulBusy), .mul_y_bi(mulY)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int y;
    int err;
    int lat;
  } exp_t;

  exp_t         sb[$];
  int           tests = 0;
  int           failed = 0;
  int           cycle = 0;
  int           startCycle = 0;
  int           mulLat = 3;
  bit           mulStuck = 1'b0;
  int           mulCnt = 0;
  logic [15:0]  mulProd = '0;
  logic [N-1:0] reraise = '0;
  logic [N-1:0] raiseNext = '0;
  int           modelPtr = 0;
  int           opA[N];
  int           opB[N];

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural multiplier: busy is seen high for mulLat cycles after the start pulse.
  always @(negedge clk) begin
    if (!rst_i) begin
      mulCnt  = 0;
      mulBusy = 1'b0;
      mulY    = '0;
    end else if (mulCnt > 0) begin
      mulCnt--;
      if (mulCnt == 0) begin
        mulBusy = 1'b0;
        mulY    = mulProd;
      end
    end else if (mul_start_o && !mulStuck) begin
      mulProd = mul_a_bo * mul_b_bo;
      mulCnt  = mulLat + 1;
      mulBusy = 1'b1;
      mulY    = 16'($urandom);
    end
  end

  // Requesters drop their line on ack; those flagged in reraise come back one cycle later.
  always @(negedge clk) begin
    if (!rst_i) begin
      req       = '0;
      raiseNext = '0;
    end else begin
      req       = req | raiseNext;
      raiseNext = '0;
      for (int k = 0; k < N; k++) begin
        if (ack_o[k]) begin
          req[k] = 1'b0;
          if (reraise[k]) begin
            reraise[k]   = 1'b0;
            raiseNext[k] = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_i === 1'b1) begin
      if (mul_start_o) startCycle = cycle;
      if (ack_o != '0) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected ack", longint'(ack_o), 0);
        end else begin
          e = sb.pop_front();
          checkOutput("ack onehot", $countones(ack_o), 1);
          checkOutput("ack", longint'(ack_o), longint'(1) << e.idx);
          checkOutput("y", longint'(y_bo), e.y);
          checkOutput("err", longint'(err_o), e.err);
          checkOutput("latency", cycle - startCycle, e.lat);
          checkOutput("busy in ack", longint'(busy_o), 1);
        end
      end
    end
  end

  function automatic int pick(input logic [N-1:0] p, input int ptr);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (ptr + i) % N;
      if (p[k]) return k;
    end
    return -1;
  endfunction

  task automatic setOperands();
    for (int k = 0; k < N; k++) begin
      aBus[k*W +: W] = opA[k][W-1:0];
      bBus[k*W +: W] = opB[k][W-1:0];
    end
  endtask

  // Runs one round: predicts the grant order, raises requests and waits for the scoreboard to drain.
  task automatic applyStimulus(input logic [N-1:0] mask, input logic [N-1:0] late,
                               input logic [N-1:0] again, input bit scramble);
    logic [N-1:0] pend;
    logic [N-1:0] again2;
    bit           lateDone;
    int           errExp;
    int           c;
    int           k;
    exp_t         e;
    pend     = mask;
    again2   = again;
    lateDone = 1'b0;
    errExp   = (mulStuck || (mulLat + 2 >= T)) ? 1 : 0;
    while (pend != '0) begin
      k     = pick(pend, modelPtr);
      e.idx = k;
      e.err = errExp;
      e.y   = errExp ? 0 : (opA[k] * opB[k]) & 16'hFFFF;
      e.lat = errExp ? T : mulLat + 2;
      sb.push_back(e);
      modelPtr = (k + 1) % N;
      pend[k]  = 1'b0;
      if (again2[k]) begin
        again2[k] = 1'b0;
        pend[k]   = 1'b1;
      end
      if (!lateDone) begin
        pend     = pend | late;
        lateDone = 1'b1;
      end
    end
    setOperands();
    @(negedge clk);
    reraise = again;
    req     = req | mask;
    if (late != '0 || scramble) begin
      c = 0;
      while (!mul_start_o && c < 100) begin
        @(negedge clk);
        c++;
      end
      req = req | late;
      if (scramble) begin
        aBus = {N{8'($urandom)}};
        bBus = {N{8'($urandom)}};
      end
    end
    c = 0;
    while (sb.size() > 0 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (sb.size() > 0) begin
      checkOutput("round drained", sb.size(), 0);
      sb.delete();
    end
    c = 0;
    while (mulCnt > 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " ack"}, longint'(ack_o), 0);
    checkOutput({tag, " y"}, longint'(y_bo), 0);
    checkOutput({tag, " err"}, longint'(err_o), 0);
    checkOutput({tag, " busy"}, longint'(busy_o), 0);
    checkOutput({tag, " start"}, longint'(mul_start_o), 0);
    checkOutput({tag, " mul_a"}, longint'(mul_a_bo), 0);
    checkOutput({tag, " mul_b"}, longint'(mul_b_bo), 0);
  endtask

  initial begin
    logic [N-1:0] m;
    int c;
    for (int k = 0; k < N; k++) begin
      opA[k] = 0;
      opB[k] = 0;
    end
    #1 checkAllZero("reset");
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    repeat (2) @(negedge clk);

    // Single job with operands scrambled after the grant
    opA[0] = 7; opB[0] = 9;
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 1'b1);

    // Operand sweep on requester 2
    for (int i = 0; i <= 10; i++) begin
      opA[2] = (i == 10) ? 255 : i;
      opB[2] = (i == 10) ? 255 : i;
      applyStimulus(4'b0100, 4'b0000, 4'b0000, 1'b0);
    end

    // ptr is now 3: 0 wins, then 2 beats the late requester 3
    opA[0] = 11; opB[0] = 3; opA[2] = 12; opB[2] = 4; opA[3] = 13; opB[3] = 5;
    applyStimulus(4'b0101, 4'b1000, 4'b0000, 1'b0);

    // Fairness: all four held, requester 0 re-raises after its ack
    for (int k = 0; k < N; k++) begin
      opA[k] = k + 1;
      opB[k] = 10;
    end
    applyStimulus(4'b1111, 4'b0000, 4'b0001, 1'b0);

    // Watchdog: stuck multiplier, then a normal job, then the busy-length boundary
    opA[2] = 5; opB[2] = 6;
    mulStuck = 1'b1;
    applyStimulus(4'b0100, 4'b0000, 4'b0000, 1'b0);
    mulStuck = 1'b0;
    applyStimulus(4'b0100, 4'b0000, 4'b0000, 1'b0);
    mulLat = T - 3;
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 1'b0);
    mulLat = T - 2;
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 1'b0);

    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < N; k++) begin
        opA[k] = $urandom_range(0, 255);
        opB[k] = $urandom_range(0, 255);
      end
      m      = 4'($urandom_range(1, 15));
      mulLat = $urandom_range(1, 8);
      applyStimulus(m, 4'($urandom) & ~m, 4'($urandom) & m, 1'b0);
    end

    // Reset in the middle of a job: everything clears, no ack follows
    mulLat = 8;
    opA[0] = 3; opB[0] = 5;
    setOperands();
    @(negedge clk);
    req = req | 4'b0001;
    c = 0;
    while (!mul_start_o && c < 100) begin
      @(negedge clk);
      c++;
    end
    repeat (3) @(negedge clk);
    #2 rst_i = 1'b0;
    #1 checkAllZero("midjob reset");
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    modelPtr = 0;
    repeat (6) @(negedge clk);

    for (int k = 0; k < N; k++) begin
      opA[k] = k + 20;
      opB[k] = 2;
    end
    mulLat = 4;
    applyStimulus(4'b1011, 4'b0000, 4'b0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
